mem_stage: RTL and testbench

- Pipeline MEM stage of the 5-stage RV32I core. Consumes the EX/MEM register (ex_mem_t), drives a req/gnt/rvalid data-memory port, and formats loads and stores.
- Produces the MEM/WB register (mem_wb_t), which feeds both writeback and EX-stage forwarding.
- Raises mem_stall to freeze upstream stages while a memory access is outstanding.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/mem_stage_load_align.sv | 37 +++
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: control bundle, EX/MEM and MEM/WB registers,
// MEM-stage FSM encoding and load/store funct3 constants.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    // Data-memory access FSM
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } mem_state_t;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] alu_result;
        logic [RV_XLEN-1:0] rs2_data;
        logic [4:0]         rd;
        ctrl_t              ctrl;
        logic [31:0]        instr;
    } ex_mem_t;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] alu_result;
        logic [RV_XLEN-1:0] mem_data;
        logic [4:0]         rd;
        ctrl_t              ctrl;
        logic [31:0]        instr;
    } mem_wb_t;

endpackage : riscv_pkg

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/halfword lane from a raw load word
// and sign- or zero-extends it according to funct3. Purely combinational.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte by full offset, halfword by offset bit 1
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extension by access type
    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule : load_align

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM pipeline stage. Drives a req/gnt/rvalid data-memory
// port, formats stores and loads, stalls upstream while an access is
// outstanding and registers the MEM/WB bundle.
// Optional: MEM_MISALIGN_TRAP_EN - misaligned accesses are not issued and
// raise a one-cycle exc_misalign pulse with the faulting address.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  ex_mem_t         ex_mem_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [BE_W-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output mem_wb_t         mem_wb_out,
    output logic            exc_misalign,
    output logic [XLEN-1:0] exc_addr
);

    mem_state_t r_state;
    mem_state_t w_state_nxt;
    mem_wb_t    r_mem_wb;

    logic [2:0]  w_funct3;
    logic [1:0]  w_off;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_trap;
    logic        w_mem_op;
    logic        w_req;
    logic        w_stall;
    logic        w_load_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_funct3   = ex_mem_in.instr[14:12];
    assign w_off      = ex_mem_in.alu_result[1:0];
    assign w_is_load  = ex_mem_in.ctrl.mem_read;
    assign w_is_store = ex_mem_in.ctrl.mem_write & ~ex_mem_in.ctrl.mem_read;
    assign w_is_mem   = ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic            w_misalign;
    logic            r_exc;
    logic [XLEN-1:0] r_exc_addr;

    // Halfword needs off[0]=0, word needs off=0; bytes are never misaligned
    always_comb begin
        case (w_funct3[1:0])
            2'b01:   w_misalign = w_off[0];
            2'b10:   w_misalign = (w_off != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    // A trap is only possible when a new op is presented (FSM idle)
    assign w_trap = (r_state == ST_IDLE) & w_is_mem & w_misalign;

    // Exception pulse and faulting-address capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_exc <= w_trap;
            if (w_trap) begin
                r_exc_addr <= ex_mem_in.alu_result;
            end
        end
    end

    assign exc_misalign = r_exc;
    assign exc_addr     = r_exc_addr;
`else
    assign w_trap       = 1'b0;
    assign exc_misalign = 1'b0;
    assign exc_addr     = '0;
`endif

    assign w_mem_op = w_is_mem & ~w_trap;

    // Store byte enables and lane-replicated write data; loads read the whole word
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_mem_in.rs2_data;
        if (w_is_store) begin
            case (w_funct3)
                F3_SB: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{ex_mem_in.rs2_data[7:0]}};
                end
                F3_SH: begin
                    w_be    = 4'b0011 << {w_off[1], 1'b0};
                    w_wdata = {2{ex_mem_in.rs2_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_mem_in.rs2_data;
                end
            endcase
        end
    end

    load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_off    (w_off),
        .i_funct3 (w_funct3),
        .o_data   (w_load_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    if (dmem_gnt) begin
                        w_state_nxt = w_is_load ? ST_WAIT_RSP : ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_GNT;
                    end
                end
            end
            ST_WAIT_GNT: begin
                if (dmem_gnt) begin
                    w_state_nxt = w_is_load ? ST_WAIT_RSP : ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (dmem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: request, stall, load completion
    always_comb begin
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req   = w_mem_op;
                w_stall = w_mem_op & ~(dmem_gnt & w_is_store);
            end
            ST_WAIT_GNT: begin
                w_req   = 1'b1;
                w_stall = ~(dmem_gnt & w_is_store);
            end
            ST_WAIT_RSP: begin
                w_stall     = ~dmem_rvalid;
                w_load_done = dmem_rvalid;
            end
            default: begin
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    // MEM/WB register: bubble while stalled, otherwise capture the instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_wb <= '0;
        end else if (w_stall) begin
            r_mem_wb <= '0;
        end else begin
            r_mem_wb.pc         <= ex_mem_in.pc;
            r_mem_wb.alu_result <= ex_mem_in.alu_result;
            r_mem_wb.mem_data   <= w_load_done ? w_load_data : '0;
            r_mem_wb.rd         <= ex_mem_in.rd;
            r_mem_wb.ctrl       <= ex_mem_in.ctrl;
            r_mem_wb.instr      <= ex_mem_in.instr;
            if (w_trap) begin
                r_mem_wb.ctrl.reg_write <= 1'b0;
            end
        end
    end

    assign dmem_req   = w_req;
    assign dmem_we    = ex_mem_in.ctrl.mem_write;
    assign dmem_addr  = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};
    assign dmem_be    = w_be;
    assign dmem_wdata = w_wdata;
    assign mem_stall  = w_stall;
    assign mem_wb_out = r_mem_wb;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expected values.
// Inputs change 1 time unit after posedge; outputs are sampled mid-cycle.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    ex_mem_t     ex_mem_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    mem_wb_t     mem_wb_out;
    logic        exc_misalign;
    logic [31:0] exc_addr;

    int unsigned n_checks;
    int unsigned n_fail;

    mem_stage #(.XLEN(32), .BE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_in    (ex_mem_in),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .mem_stall    (mem_stall),
        .mem_wb_out   (mem_wb_out),
        .exc_misalign (exc_misalign),
        .exc_addr     (exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_t make_op(input logic [31:0] pc, input logic [31:0] alu,
                                        input logic [31:0] rs2, input logic [4:0] rd,
                                        input logic rw, input logic mr, input logic mw,
                                        input logic [2:0] f3);
        ex_mem_t op;
        op.pc              = pc;
        op.alu_result      = alu;
        op.rs2_data        = rs2;
        op.rd              = rd;
        op.ctrl.reg_write  = rw;
        op.ctrl.mem_read   = mr;
        op.ctrl.mem_write  = mw;
        op.ctrl.mem_to_reg = mr;
        op.instr           = {17'd0, f3, rd, 7'h03};
        return op;
    endfunction

    // Advance to 1 unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a load with immediate grant, two empty wait cycles, then rvalid
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        ex_mem_in = make_op(32'h100, addr, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3);
        dmem_gnt  = 1'b1;
        #2;
        check_eq({tag, "_req"},   dmem_req, 1);
        check_eq({tag, "_addr"},  dmem_addr, {addr[31:2], 2'b00});
        check_eq({tag, "_be"},    dmem_be, 4'b1111);
        check_eq({tag, "_stall"}, mem_stall, 1);
        step();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            check_eq({tag, "_wstall"}, mem_stall, 1);
            check_eq({tag, "_wreq"},   dmem_req, 0);
            check_eq({tag, "_bubble"}, 32'(mem_wb_out != '0), 0);
            step();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #2;
        check_eq({tag, "_rvstall"}, mem_stall, 0);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hDEAD_BEEF;
        check_eq({tag, "_data"}, mem_wb_out.mem_data, exp);
        check_eq({tag, "_rd"},   mem_wb_out.rd, 7);
        ex_mem_in = '0;
        #2;
        check_eq({tag, "_idle"}, dmem_req, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        ex_mem_in   = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        step();
        step();
        check_eq("rst_wb",   32'(mem_wb_out != '0), 0);
        check_eq("rst_exc",  exc_misalign, 0);
        check_eq("rst_eadr", exc_addr, 0);
        rst = 1'b0;

        // Non-memory op: one-cycle registered pass-through
        ex_mem_in = make_op(32'h40, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        #2;
        check_eq("add_req",   dmem_req, 0);
        check_eq("add_stall", mem_stall, 0);
        step();
        check_eq("add_alu",  mem_wb_out.alu_result, 32'h1234);
        check_eq("add_rd",   mem_wb_out.rd, 5);
        check_eq("add_mdat", mem_wb_out.mem_data, 0);
        check_eq("add_rw",   mem_wb_out.ctrl.reg_write, 1);

        // Stale rvalid in IDLE is ignored
        ex_mem_in   = '0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        #2;
        check_eq("stale_stall", mem_stall, 0);
        step();
        check_eq("stale_wb", 32'(mem_wb_out != '0), 0);
        dmem_rvalid = 1'b0;

        // SB at 0x1003, grant withheld for two cycles
        ex_mem_in = make_op(32'h44, 32'h1003, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, F3_SB);
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 2);
            #2;
            check_eq("sb_req",   dmem_req, 1);
            check_eq("sb_we",    dmem_we, 1);
            check_eq("sb_addr",  dmem_addr, 32'h1000);
            check_eq("sb_be",    dmem_be, 4'b1000);
            check_eq("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
            check_eq("sb_stall", mem_stall, (c == 2) ? 0 : 1);
            step();
            if (c < 2) check_eq("sb_bubble", 32'(mem_wb_out != '0), 0);
        end
        dmem_gnt = 1'b0;
        check_eq("sb_wb_alu", mem_wb_out.alu_result, 32'h1003);
        check_eq("sb_wb_pc",  mem_wb_out.pc, 32'h44);
        ex_mem_in = '0;
        #2;
        check_eq("sb_done_req", dmem_req, 0);
        step();

        // SH at 0x1002, immediate grant
        ex_mem_in = make_op(32'h48, 32'h1002, 32'h1234_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, F3_SH);
        dmem_gnt  = 1'b1;
        #2;
        check_eq("sh_be",    dmem_be, 4'b1100);
        check_eq("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check_eq("sh_stall", mem_stall, 0);
        step();
        // SW at 0x1004, immediate grant
        ex_mem_in = make_op(32'h4C, 32'h1004, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, F3_SW);
        #2;
        check_eq("sw_be",    dmem_be, 4'b1111);
        check_eq("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        check_eq("sw_addr",  dmem_addr, 32'h1004);
        step();
        check_eq("sw_wb_pc", mem_wb_out.pc, 32'h4C);
        dmem_gnt  = 1'b0;
        ex_mem_in = '0;
        step();

        // Load formatting
        do_load("lb",   F3_LB,  32'h2002, 32'h0080_0000, 32'hFFFF_FF80);
        do_load("lbu",  F3_LBU, 32'h2002, 32'h0080_0000, 32'h0000_0080);
        do_load("lb0",  F3_LB,  32'h2000, 32'h1234_5678, 32'h0000_0078);
        do_load("lh",   F3_LH,  32'h2002, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu",  F3_LHU, 32'h2002, 32'h8001_0000, 32'h0000_8001);
        do_load("lw",   F3_LW,  32'h2000, 32'h8001_0000, 32'h8001_0000);

        // Reset while waiting for a response; later rvalid must be ignored
        ex_mem_in = make_op(32'h60, 32'h2000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LW);
        dmem_gnt  = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #2;
        check_eq("rsp_stall", mem_stall, 1);
        rst = 1'b1;
        step();
        check_eq("midrst_wb", 32'(mem_wb_out != '0), 0);
        rst         = 1'b0;
        ex_mem_in   = '0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_5555;
        #2;
        check_eq("midrst_req",   dmem_req, 0);
        check_eq("midrst_stall", mem_stall, 0);
        step();
        check_eq("midrst_mdat", mem_wb_out.mem_data, 0);
        dmem_rvalid = 1'b0;

        // LW at 0x3001
`ifdef MEM_MISALIGN_TRAP_EN
        ex_mem_in = make_op(32'h70, 32'h3001, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, F3_LW);
        dmem_gnt  = 1'b1;
        #2;
        check_eq("mis_req",   dmem_req, 0);
        check_eq("mis_stall", mem_stall, 0);
        step();
        dmem_gnt  = 1'b0;
        ex_mem_in = '0;
        check_eq("mis_exc",  exc_misalign, 1);
        check_eq("mis_addr", exc_addr, 32'h3001);
        check_eq("mis_rw",   mem_wb_out.ctrl.reg_write, 0);
        check_eq("mis_alu",  mem_wb_out.alu_result, 32'h3001);
        step();
        check_eq("mis_pulse", exc_misalign, 0);
`else
        do_load("lwmis", F3_LW, 32'h3001, 32'h0BAD_F00D, 32'h0BAD_F00D);
        check_eq("mis_exc",  exc_misalign, 0);
        check_eq("mis_addr", exc_addr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_stage
